// File: rtl/cnn16_ram_dp_if.sv
// Port bundle for cnn16_ram_dp: load/store port A, fetch port B, clear control.
// master = requester side, slave = the memory itself.
interface cnn16_ram_dp_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);
    logic                      a_en;
    logic                      a_we;
    logic [DATA_WIDTH/8-1:0]   a_be;
    logic [ADDR_WIDTH-1:0]     a_addr;
    logic [DATA_WIDTH-1:0]     a_wdata;
    logic [DATA_WIDTH-1:0]     a_rdata;
    logic                      a_rvalid;

    logic                      b_en;
    logic [ADDR_WIDTH-1:0]     b_addr;
    logic [DATA_WIDTH-1:0]     b_rdata;
    logic                      b_rvalid;

    logic                      clear_req;
    logic                      init_busy;

    modport master (
        output a_en, a_we, a_be, a_addr, a_wdata,
        output b_en, b_addr,
        output clear_req,
        input  a_rdata, a_rvalid, b_rdata, b_rvalid, init_busy
    );

    modport slave (
        input  a_en, a_we, a_be, a_addr, a_wdata,
        input  b_en, b_addr,
        input  clear_req,
        output a_rdata, a_rvalid, b_rdata, b_rvalid, init_busy
    );
endinterface

// File: rtl/cnn16_ram_dp.sv
// CNN16 dual-port data memory: port A read/write with byte enables, port B read-only,
// registered reads with valid strobes, and a sequencer that zeroes the whole array.
module cnn16_ram_dp #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 12,
    parameter int READ_MODE      = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    cnn16_ram_dp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    a_wr_go, a_rd_go, b_rd_go;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [NB-1:0]           wr_be;

    logic [DATA_WIDTH-1:0]   b_raw, b_word;
    logic                    b_collide;

    logic [DATA_WIDTH-1:0]   a_rdata_q, b_rdata_q;
    logic                    a_rvalid_q, b_rvalid_q;

    // A clear_req seen in IDLE takes the array on the same edge, so that cycle's
    // accesses are dropped along with everything issued during CLEAR.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    accept  = 1'b1;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign a_wr_go = accept & bus.a_en &  bus.a_we;
    assign a_rd_go = accept & bus.a_en & ~bus.a_we;
    assign b_rd_go = accept & bus.b_en;

    // Single write port shared by the clear sequencer and port A.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.a_addr;
        wr_data = bus.a_wdata;
        wr_be   = bus.a_be;
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
            wr_be   = '1;
        end else if (a_wr_go) begin
            wr_en   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_en && wr_be[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign b_raw     = mem[bus.b_addr];
    assign b_collide = (READ_MODE == 1) && a_wr_go && (bus.a_addr == bus.b_addr);

    // Write-first bypass: enabled bytes come from the incoming write data.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_b_merge
            assign b_word[8*gi +: 8] = (b_collide && bus.a_be[gi]) ? bus.a_wdata[8*gi +: 8]
                                                                    : b_raw[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt_q      <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_rvalid_q <= a_rd_go;
            b_rvalid_q <= b_rd_go;
            if (a_rd_go) begin
                a_rdata_q <= mem[bus.a_addr];
            end
            if (b_rd_go) begin
                b_rdata_q <= b_word;
            end
        end
    end

    assign bus.a_rdata   = a_rdata_q;
    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.b_rvalid  = b_rvalid_q;
    assign bus.init_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_cnn16_ram_dp.sv
// Random and directed bench for cnn16_ram_dp: read-first and write-first instances
// run in lockstep against one behavioural memory model.
module tb_cnn16_ram_dp;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;

    cnn16_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    cnn16_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    assign bus1.a_en      = bus0.a_en;
    assign bus1.a_we      = bus0.a_we;
    assign bus1.a_be      = bus0.a_be;
    assign bus1.a_addr    = bus0.a_addr;
    assign bus1.a_wdata   = bus0.a_wdata;
    assign bus1.b_en      = bus0.b_en;
    assign bus1.b_addr    = bus0.b_addr;
    assign bus1.clear_req = bus0.clear_req;

    cnn16_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(0), .CLEAR_ON_RESET(1))
        u_dut_rf (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
    cnn16_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(1), .CLEAR_ON_RESET(1))
        u_dut_wf (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int busy_edges = 0;
    int rv_seen  = 0;

    // Behavioural model: contents, pending clear length, expected outputs.
    logic [15:0] mem_m [DEPTH];
    int          busy_left;
    logic        exp_av, exp_bv;
    logic [15:0] exp_a, exp_b0, exp_b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy_left = DEPTH;
        exp_av = 1'b0;
        exp_bv = 1'b0;
        exp_a  = 16'h0;
        exp_b0 = 16'h0;
        exp_b1 = 16'h0;
    endtask

    task automatic model_edge(input logic ae, input logic awe, input logic [1:0] be,
                              input logic [3:0] aa, input logic [15:0] wd,
                              input logic be_n, input logic [3:0] ba, input logic clr);
        logic [15:0] oldv, newv;
        if (busy_left > 0) begin
            exp_av = 1'b0;
            exp_bv = 1'b0;
            busy_left--;
            if (busy_left == 0) begin
                for (int k = 0; k < DEPTH; k++) mem_m[k] = 16'h0;
            end
        end else if (clr) begin
            busy_left = DEPTH;
            exp_av = 1'b0;
            exp_bv = 1'b0;
        end else begin
            oldv = mem_m[aa];
            newv = {be[1] ? wd[15:8] : oldv[15:8], be[0] ? wd[7:0] : oldv[7:0]};
            exp_av = ae && !awe;
            if (exp_av) exp_a = mem_m[aa];
            exp_bv = be_n;
            if (be_n) begin
                exp_b0 = mem_m[ba];
                exp_b1 = (ae && awe && aa == ba) ? newv : mem_m[ba];
            end
            if (ae && awe) mem_m[aa] = newv;
        end
    endtask

    task automatic compare_all();
        chk("a_rvalid_rf", {31'b0, bus0.a_rvalid}, {31'b0, exp_av});
        chk("a_rvalid_wf", {31'b0, bus1.a_rvalid}, {31'b0, exp_av});
        chk("b_rvalid_rf", {31'b0, bus0.b_rvalid}, {31'b0, exp_bv});
        chk("b_rvalid_wf", {31'b0, bus1.b_rvalid}, {31'b0, exp_bv});
        chk("a_rdata_rf", {16'b0, bus0.a_rdata}, {16'b0, exp_a});
        chk("a_rdata_wf", {16'b0, bus1.a_rdata}, {16'b0, exp_a});
        chk("b_rdata_rf", {16'b0, bus0.b_rdata}, {16'b0, exp_b0});
        chk("b_rdata_wf", {16'b0, bus1.b_rdata}, {16'b0, exp_b1});
        chk("init_busy_rf", {31'b0, bus0.init_busy}, {31'b0, (busy_left > 0)});
        chk("init_busy_wf", {31'b0, bus1.init_busy}, {31'b0, (busy_left > 0)});
    endtask

    // One clock: drive at negedge, model on posedge, compare 1 time unit later.
    task automatic cycle(input logic ae, input logic awe, input logic [1:0] be,
                         input logic [3:0] aa, input logic [15:0] wd,
                         input logic be_n, input logic [3:0] ba, input logic clr);
        bus0.a_en = ae; bus0.a_we = awe; bus0.a_be = be; bus0.a_addr = aa;
        bus0.a_wdata = wd; bus0.b_en = be_n; bus0.b_addr = ba; bus0.clear_req = clr;
        if (rst_n && bus0.init_busy === 1'b1) busy_edges++;
        @(posedge clk);
        if (rst_n) model_edge(ae, awe, be, aa, wd, be_n, ba, clr);
        #1;
        compare_all();
        if (bus0.a_rvalid || bus0.b_rvalid || bus1.a_rvalid || bus1.b_rvalid) rv_seen++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 2'b00, 4'h0, 16'h0, 0, 4'h0, 0);
    endtask

    task automatic wr(input logic [3:0] aa, input logic [15:0] wd, input logic [1:0] be);
        cycle(1, 1, be, aa, wd, 0, 4'h0, 0);
    endtask

    task automatic read_all_zero(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1, 0, 2'b00, 4'(k), 16'h0, 1, 4'(DEPTH - 1 - k), 0);
            chk({tag, "_a"}, {15'b0, bus0.a_rvalid, bus0.a_rdata}, {15'b0, 1'b1, 16'h0000});
            chk({tag, "_b"}, {15'b0, bus1.b_rvalid, bus1.b_rdata}, {15'b0, 1'b1, 16'h0000});
        end
    endtask

    initial begin
        logic [31:0] r;
        for (int k = 0; k < DEPTH; k++) mem_m[k] = 16'h0;
        rst_n = 1'b0;
        bus0.a_en = 0; bus0.a_we = 0; bus0.a_be = 0; bus0.a_addr = 0;
        bus0.a_wdata = 0; bus0.b_en = 0; bus0.b_addr = 0; bus0.clear_req = 0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_a_rdata", {16'b0, bus0.a_rdata}, 32'h0);
        chk("rst_rvalids", {28'b0, bus0.a_rvalid, bus0.b_rvalid, bus1.a_rvalid, bus1.b_rvalid}, 32'h0);
        chk("rst_busy", {31'b0, bus0.init_busy}, 32'h1);

        // Reset clear: busy for exactly 16 edges, then all zero
        rst_n = 1'b1;
        busy_edges = 0;
        idle(20);
        chk("reset_clear_len", busy_edges, 16);
        read_all_zero("reset_clear_rd");

        // Byte enables
        wr(4'd5, 16'hBEEF, 2'b11);
        wr(4'd5, 16'h1234, 2'b01);
        cycle(1, 0, 2'b00, 4'd5, 16'h0, 0, 4'h0, 0);
        chk("byte_en_data", {16'b0, bus0.a_rdata}, 32'h0000BE34);
        chk("byte_en_valid", {31'b0, bus0.a_rvalid}, 32'h1);
        idle(1);
        chk("byte_en_strobe_drop", {31'b0, bus0.a_rvalid}, 32'h0);

        // Collision
        wr(4'd3, 16'hAAAA, 2'b11);
        cycle(1, 1, 2'b11, 4'd3, 16'h5555, 1, 4'd3, 0);
        chk("collide_rf", {16'b0, bus0.b_rdata}, 32'h0000AAAA);
        chk("collide_wf", {16'b0, bus1.b_rdata}, 32'h00005555);
        cycle(0, 0, 2'b00, 4'h0, 16'h0, 1, 4'd3, 0);
        chk("collide_after_rf", {16'b0, bus0.b_rdata}, 32'h00005555);
        chk("collide_after_wf", {16'b0, bus1.b_rdata}, 32'h00005555);

        // Dual streaming
        for (int i = 0; i <= DEPTH; i++) begin
            cycle(i < DEPTH, 1, 2'b11, 4'(i), 16'(i + 16'h100), 1, 4'(i - 1), 0);
            if (i >= 1) begin
                chk("stream_b", {15'b0, bus0.b_rvalid, bus0.b_rdata}, {15'b0, 1'b1, 16'(i - 1 + 16'h100)});
            end
        end

        // Random traffic with occasional clear requests
        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            cycle(r[0], r[1], r[3:2], r[7:4], r[23:8], r[24], r[25] ? r[7:4] : r[29:26],
                  (r[31:30] == 2'b11) && ($urandom_range(0, 15) == 0));
        end
        idle(DEPTH + 1);

        // clear_req mid-traffic
        for (int k = 0; k < DEPTH; k++) wr(4'(k), 16'hFFFF, 2'b11);
        rv_seen = 0;
        cycle(1, 0, 2'b00, 4'd2, 16'h0, 1, 4'd9, 1);
        for (int k = 0; k < DEPTH; k++) begin
            r = $urandom;
            cycle(1, r[0], 2'b11, r[7:4], r[23:8], 1, r[11:8], 0);
        end
        chk("clearreq_no_rvalid", rv_seen, 0);
        chk("clearreq_done", {31'b0, bus0.init_busy}, 32'h0);
        read_all_zero("clearreq_rd");

        // Reset mid-read
        cycle(1, 0, 2'b00, 4'd5, 16'h0, 1, 4'd3, 0);
        chk("midread_pre", {30'b0, bus0.a_rvalid, bus0.b_rvalid}, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("midread_async_rv", {28'b0, bus0.a_rvalid, bus0.b_rvalid, bus1.a_rvalid, bus1.b_rvalid}, 32'h0);
        chk("midread_async_rd", {16'b0, bus0.a_rdata}, 32'h0);
        model_reset();
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;
        busy_edges = 0;
        idle(20);
        chk("midread_clear_len", busy_edges, 16);

        // Reset mid-clear
        for (int k = 0; k < DEPTH; k++) wr(4'(k), 16'(16'hC000 + k), 2'b11);
        cycle(0, 0, 2'b00, 4'h0, 16'h0, 0, 4'h0, 1);
        idle(7);
        rst_n = 1'b0;
        #1;
        chk("midclear_rv", {28'b0, bus0.a_rvalid, bus0.b_rvalid, bus1.a_rvalid, bus1.b_rvalid}, 32'h0);
        chk("midclear_busy", {31'b0, bus0.init_busy}, 32'h1);
        model_reset();
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;
        busy_edges = 0;
        idle(20);
        chk("midclear_restart_len", busy_edges, 16);
        read_all_zero("midclear_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
